// File: rtl/xif_arb_pkg.sv
// Shared types and constants for the XIF coprocessor arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Owner indices are sized for the largest supported coprocessor count (8). This lets one
// scoreboard entry type serve every NUM_CP setting.
package xif_arb_pkg;

  localparam int MAX_CP   = 8;
  localparam int CP_IDX_W = $clog2(MAX_CP);

  // One scoreboard slot per XIF instruction ID.
  typedef struct packed {
    logic                busy;
    logic                committed;
    logic [CP_IDX_W-1:0] owner;
  } sb_entry_t;

endpackage

// File: rtl/xif_rr_arbiter.sv
// Round-robin arbiter for coprocessor results. It can hold its grant while the consumer stalls.
// Latency: grant is combinational from req; the pointer and lock update on the clock edge.
// Backpressure: hold_i freezes the current grant until ack_i completes the handshake.
// Ports: clk_i/rst_ni    clock, async active-low reset
//        req_i           per-requester request
//        hold_i          grant presented but not accepted this cycle
//        ack_i           grant accepted this cycle (advances pointer)
//        gnt_oh_o        one-hot grant (zero when no request and not locked)
//        gnt_idx_o       binary index of the grant
module xif_rr_arbiter
  import xif_arb_pkg::*;
#(
  parameter int NUM_CP = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_CP-1:0]   req_i,
  input  logic                hold_i,
  input  logic                ack_i,
  output logic [NUM_CP-1:0]   gnt_oh_o,
  output logic [CP_IDX_W-1:0] gnt_idx_o
);

  logic [CP_IDX_W-1:0] ptr_q;
  logic                lock_q;
  logic [CP_IDX_W-1:0] lock_idx_q;
  logic                found;
  logic [CP_IDX_W-1:0] search_idx;

  // Search for the first requester at or after the pointer, wrapping at NUM_CP-1.
  // The nested constant loops keep every bit select static.
  always_comb begin
    found      = 1'b0;
    search_idx = '0;
    for (int i = 0; i < NUM_CP; i++) begin
      for (int k = 0; k < NUM_CP; k++) begin
        if (!found && req_i[k] && (k == ((int'(ptr_q) + i) % NUM_CP))) begin
          found      = 1'b1;
          search_idx = CP_IDX_W'(k);
        end
      end
    end
  end

  // While locked, the grant stays on the stalled requester. XIF requires it to keep its
  // result stable until accepted.
  always_comb begin
    gnt_idx_o = lock_q ? lock_idx_q : search_idx;
    gnt_oh_o  = '0;
    for (int k = 0; k < NUM_CP; k++) begin
      gnt_oh_o[k] = (lock_q || found) && (gnt_idx_o == CP_IDX_W'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (ack_i) begin
      ptr_q  <= (int'(gnt_idx_o) == NUM_CP - 1) ? '0 : gnt_idx_o + CP_IDX_W'(1);
      lock_q <= 1'b0;
    end else if (hold_i) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/xif_coproc_arbiter.sv
// Shares one CORE-V-XIF offload path among NUM_CP coprocessors.
// Issue, commit and result phases are covered.
// Latency: issue, commit and result paths are combinational (0 cycles).
//          The scoreboard, outstanding_o and err_o update one cycle later.
// Backpressure: issue stalls while the issued ID is still busy or any coprocessor is not ready.
//               A stalled result keeps its grant locked until result_ready_i.
// Ports: issue_*    core issue handshake; cp_issue_* fan-out to coprocessors
//        commit_*   core commit; cp_commit_* per-coprocessor valid/kill
//        cp_result_* per-coprocessor results; result_* the arbitrated result to the core
//        outstanding_o number of busy IDs; err_o pulse on a result from a non-owner
module xif_coproc_arbiter
  import xif_arb_pkg::*;
#(
  parameter int NUM_CP  = 2,
  parameter int X_ID_W  = 4,
  parameter int X_RFW_W = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // issue
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [X_ID_W-1:0]         issue_id_i,
  output logic                      issue_accept_o,
  output logic                      issue_writeback_o,
  output logic [NUM_CP-1:0]         cp_issue_valid_o,
  input  logic [NUM_CP-1:0]         cp_issue_ready_i,
  input  logic [NUM_CP-1:0]         cp_issue_accept_i,
  input  logic [NUM_CP-1:0]         cp_issue_writeback_i,
  // commit
  input  logic                      commit_valid_i,
  input  logic [X_ID_W-1:0]         commit_id_i,
  input  logic                      commit_kill_i,
  output logic [NUM_CP-1:0]         cp_commit_valid_o,
  output logic [NUM_CP-1:0]         cp_commit_kill_o,
  // result
  input  logic [NUM_CP-1:0]         cp_result_valid_i,
  output logic [NUM_CP-1:0]         cp_result_ready_o,
  input  logic [NUM_CP*X_ID_W-1:0]  cp_result_id_i,
  input  logic [NUM_CP*5-1:0]       cp_result_rd_i,
  input  logic [NUM_CP-1:0]         cp_result_we_i,
  input  logic [NUM_CP*X_RFW_W-1:0] cp_result_data_i,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic [X_ID_W-1:0]         result_id_o,
  output logic [4:0]                result_rd_o,
  output logic                      result_we_o,
  output logic [X_RFW_W-1:0]        result_data_o,
  // status
  output logic [X_ID_W:0]           outstanding_o,
  output logic                      err_o
);

  localparam int DEPTH = 1 << X_ID_W;

  sb_entry_t sb     [DEPTH];
  sb_entry_t sb_nxt [DEPTH];

  // ---------------- issue ----------------
  sb_entry_t           issue_ent;
  logic                issue_busy;
  logic                issue_hs;
  logic [NUM_CP-1:0]   accept_oh;
  logic [CP_IDX_W-1:0] issue_owner;

  assign issue_ent        = sb[issue_id_i];
  assign issue_busy       = issue_ent.busy;
  assign cp_issue_valid_o = issue_busy ? '0 : {NUM_CP{issue_valid_i}};
  assign issue_ready_o    = !issue_busy && (&cp_issue_ready_i);
  assign issue_hs         = issue_valid_i && issue_ready_o;
  assign issue_accept_o   = |cp_issue_accept_i;

  // The lowest accepting coprocessor owns the instruction. Its writeback flag is the one
  // reported to the core.
  assign accept_oh         = cp_issue_accept_i & (~cp_issue_accept_i + NUM_CP'(1));
  assign issue_writeback_o = |(accept_oh & cp_issue_writeback_i);

  always_comb begin
    issue_owner = '0;
    for (int k = NUM_CP - 1; k >= 0; k--) begin
      if (cp_issue_accept_i[k]) issue_owner = CP_IDX_W'(k);
    end
  end

  // ---------------- commit ----------------
  sb_entry_t commit_ent;

  assign commit_ent        = sb[commit_id_i];
  assign cp_commit_valid_o = {NUM_CP{commit_valid_i}};

  // Only the recorded owner of a busy ID may keep the instruction. Every other coprocessor
  // is told to drop it.
  always_comb begin
    cp_commit_kill_o = '0;
    for (int k = 0; k < NUM_CP; k++) begin
      cp_commit_kill_o[k] = commit_kill_i ||
                            !(commit_ent.busy && (commit_ent.owner == CP_IDX_W'(k)));
    end
  end

  // ---------------- result ----------------
  logic [NUM_CP-1:0]   gnt_oh;
  logic [CP_IDX_W-1:0] gnt_idx;
  logic                res_hs;
  logic                res_hold;
  sb_entry_t           res_ent;
  logic                err_nxt;

  assign result_valid_o    = |cp_result_valid_i;
  assign cp_result_ready_o = gnt_oh & {NUM_CP{result_ready_i}};
  assign res_hs            = result_valid_o && result_ready_i;
  assign res_hold          = result_valid_o && !result_ready_i;

  xif_rr_arbiter #(
    .NUM_CP (NUM_CP)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (cp_result_valid_i),
    .hold_i    (res_hold),
    .ack_i     (res_hs),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    result_id_o   = '0;
    result_rd_o   = '0;
    result_we_o   = 1'b0;
    result_data_o = '0;
    for (int k = 0; k < NUM_CP; k++) begin
      if (gnt_oh[k]) begin
        result_id_o   = cp_result_id_i[k*X_ID_W +: X_ID_W];
        result_rd_o   = cp_result_rd_i[k*5 +: 5];
        result_we_o   = cp_result_we_i[k];
        result_data_o = cp_result_data_i[k*X_RFW_W +: X_RFW_W];
      end
    end
  end

  // A result for an ID that is idle, or that belongs to another coprocessor, is flagged.
  // The entry is still freed.
  assign res_ent = sb[result_id_o];
  assign err_nxt = res_hs && (!res_ent.busy || (res_ent.owner != gnt_idx));

  // ---------------- scoreboard next state ----------------
  // Frees are applied before the issue write. An issue can only hit an idle ID, so
  // legitimate traffic never collides. A stray result to an ID being issued loses to the issue.
  always_comb begin
    sb_nxt = sb;
    if (commit_valid_i && commit_ent.busy) begin
      if (commit_kill_i) sb_nxt[commit_id_i].busy      = 1'b0;
      else               sb_nxt[commit_id_i].committed = 1'b1;
    end
    if (res_hs) begin
      sb_nxt[result_id_o].busy = 1'b0;
    end
    if (issue_hs && issue_accept_o) begin
      sb_nxt[issue_id_i].busy      = 1'b1;
      sb_nxt[issue_id_i].committed = 1'b0;
      sb_nxt[issue_id_i].owner     = issue_owner;
    end
  end

  logic [X_ID_W:0] busy_cnt;

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt = busy_cnt + {{X_ID_W{1'b0}}, sb_nxt[i].busy};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
      outstanding_o <= '0;
      err_o         <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= sb_nxt[i];
      outstanding_o <= busy_cnt;
      err_o         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_xif_coproc_arbiter.sv
// Directed self-checking bench for xif_coproc_arbiter (NUM_CP=2, X_ID_W=4, X_RFW_W=32).
// Inputs are driven 1 ns after the rising edge and combinational outputs are checked 1 ns later.
// Registered outputs are checked right after the edge.
module tb_xif_coproc_arbiter;

  localparam int NUM_CP  = 2;
  localparam int X_ID_W  = 4;
  localparam int X_RFW_W = 32;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic                      issue_valid_i;
  logic                      issue_ready_o;
  logic [X_ID_W-1:0]         issue_id_i;
  logic                      issue_accept_o;
  logic                      issue_writeback_o;
  logic [NUM_CP-1:0]         cp_issue_valid_o;
  logic [NUM_CP-1:0]         cp_issue_ready_i;
  logic [NUM_CP-1:0]         cp_issue_accept_i;
  logic [NUM_CP-1:0]         cp_issue_writeback_i;
  logic                      commit_valid_i;
  logic [X_ID_W-1:0]         commit_id_i;
  logic                      commit_kill_i;
  logic [NUM_CP-1:0]         cp_commit_valid_o;
  logic [NUM_CP-1:0]         cp_commit_kill_o;
  logic [NUM_CP-1:0]         cp_result_valid_i;
  logic [NUM_CP-1:0]         cp_result_ready_o;
  logic [NUM_CP*X_ID_W-1:0]  cp_result_id_i;
  logic [NUM_CP*5-1:0]       cp_result_rd_i;
  logic [NUM_CP-1:0]         cp_result_we_i;
  logic [NUM_CP*X_RFW_W-1:0] cp_result_data_i;
  logic                      result_valid_o;
  logic                      result_ready_i;
  logic [X_ID_W-1:0]         result_id_o;
  logic [4:0]                result_rd_o;
  logic                      result_we_o;
  logic [X_RFW_W-1:0]        result_data_o;
  logic [X_ID_W:0]           outstanding_o;
  logic                      err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  xif_coproc_arbiter #(
    .NUM_CP  (NUM_CP),
    .X_ID_W  (X_ID_W),
    .X_RFW_W (X_RFW_W)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .issue_valid_i        (issue_valid_i),
    .issue_ready_o        (issue_ready_o),
    .issue_id_i           (issue_id_i),
    .issue_accept_o       (issue_accept_o),
    .issue_writeback_o    (issue_writeback_o),
    .cp_issue_valid_o     (cp_issue_valid_o),
    .cp_issue_ready_i     (cp_issue_ready_i),
    .cp_issue_accept_i    (cp_issue_accept_i),
    .cp_issue_writeback_i (cp_issue_writeback_i),
    .commit_valid_i       (commit_valid_i),
    .commit_id_i          (commit_id_i),
    .commit_kill_i        (commit_kill_i),
    .cp_commit_valid_o    (cp_commit_valid_o),
    .cp_commit_kill_o     (cp_commit_kill_o),
    .cp_result_valid_i    (cp_result_valid_i),
    .cp_result_ready_o    (cp_result_ready_o),
    .cp_result_id_i       (cp_result_id_i),
    .cp_result_rd_i       (cp_result_rd_i),
    .cp_result_we_i       (cp_result_we_i),
    .cp_result_data_i     (cp_result_data_i),
    .result_valid_o       (result_valid_o),
    .result_ready_i       (result_ready_i),
    .result_id_o          (result_id_o),
    .result_rd_o          (result_rd_o),
    .result_we_o          (result_we_o),
    .result_data_o        (result_data_o),
    .outstanding_o        (outstanding_o),
    .err_o                (err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i        = 1'b0;
    issue_id_i           = '0;
    cp_issue_ready_i     = '0;
    cp_issue_accept_i    = '0;
    cp_issue_writeback_i = '0;
    commit_valid_i       = 1'b0;
    commit_id_i          = '0;
    commit_kill_i        = 1'b0;
    cp_result_valid_i    = '0;
    cp_result_id_i       = '0;
    cp_result_rd_i       = '0;
    cp_result_we_i       = '0;
    cp_result_data_i     = '0;
    result_ready_i       = 1'b0;
  endtask

  // Issue one instruction with all coprocessors ready; the handshake occurs at the next edge.
  task automatic do_issue(input logic [3:0] id, input logic [1:0] acc, input logic [1:0] wb);
    issue_valid_i        = 1'b1;
    issue_id_i           = id;
    cp_issue_ready_i     = 2'b11;
    cp_issue_accept_i    = acc;
    cp_issue_writeback_i = wb;
  endtask

  // Present results from both coprocessors: {cp1, cp0} packing.
  task automatic set_results(input logic [1:0] vld,
                             input logic [3:0] id1, input logic [3:0] id0,
                             input logic [31:0] d1, input logic [31:0] d0);
    cp_result_valid_i = vld;
    cp_result_id_i    = {id1, id0};
    cp_result_rd_i    = {5'd11, 5'd10};
    cp_result_we_i    = 2'b11;
    cp_result_data_i  = {d1, d0};
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_result_valid", 64'(result_valid_o), 64'd0);
    check("rst_cp_issue_valid", 64'(cp_issue_valid_o), 64'd0);
    check("rst_cp_result_ready", 64'(cp_result_ready_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // ---- single issue id=3 to cp1 with writeback ----
    do_issue(4'd3, 2'b10, 2'b10);
    settle();
    check("iss3_cp_valid", 64'(cp_issue_valid_o), 64'b11);
    check("iss3_ready", 64'(issue_ready_o), 64'd1);
    check("iss3_accept", 64'(issue_accept_o), 64'd1);
    check("iss3_writeback", 64'(issue_writeback_o), 64'd1);
    tick();
    idle_inputs();
    check("iss3_outstanding", 64'(outstanding_o), 64'd1);

    commit_valid_i = 1'b1;
    commit_id_i    = 4'd3;
    settle();
    check("cmt3_valid", 64'(cp_commit_valid_o), 64'b11);
    check("cmt3_kill", 64'(cp_commit_kill_o), 64'b01);
    tick();
    idle_inputs();

    set_results(2'b10, 4'd3, 4'd0, 32'hDEADBEEF, 32'h0);
    result_ready_i = 1'b1;
    settle();
    check("res3_valid", 64'(result_valid_o), 64'd1);
    check("res3_id", 64'(result_id_o), 64'd3);
    check("res3_data", 64'(result_data_o), 64'hDEADBEEF);
    check("res3_rd", 64'(result_rd_o), 64'd11);
    check("res3_ready_o", 64'(cp_result_ready_o), 64'b10);
    tick();
    idle_inputs();
    check("res3_outstanding", 64'(outstanding_o), 64'd0);
    check("res3_err", 64'(err_o), 64'd0);

    // ---- double accept id=5: cp0 owns, cp0 writeback flag reported ----
    do_issue(4'd5, 2'b11, 2'b01);
    settle();
    check("iss5_writeback", 64'(issue_writeback_o), 64'd1);
    tick();
    idle_inputs();
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd5;
    settle();
    check("cmt5_kill", 64'(cp_commit_kill_o), 64'b10);
    tick();
    idle_inputs();
    set_results(2'b01, 4'd0, 4'd5, 32'h0, 32'h55);
    result_ready_i = 1'b1;
    tick();
    idle_inputs();
    check("res5_err", 64'(err_o), 64'd0);
    check("res5_outstanding", 64'(outstanding_o), 64'd0);

    // ---- busy stall on id=2 ----
    do_issue(4'd2, 2'b01, 2'b00);
    tick();
    idle_inputs();
    check("iss2_outstanding", 64'(outstanding_o), 64'd1);
    do_issue(4'd2, 2'b01, 2'b00);
    settle();
    check("stall_ready", 64'(issue_ready_o), 64'd0);
    check("stall_cp_valid", 64'(cp_issue_valid_o), 64'd0);
    tick();
    check("stall_ready_hold", 64'(issue_ready_o), 64'd0);
    set_results(2'b01, 4'd0, 4'd2, 32'h0, 32'h22);
    result_ready_i = 1'b1;
    settle();
    check("stall_same_cycle_free", 64'(issue_ready_o), 64'd0);
    tick();
    cp_result_valid_i = '0;
    result_ready_i    = 1'b0;
    settle();
    check("stall_released", 64'(issue_ready_o), 64'd1);
    tick();
    idle_inputs();
    check("reiss2_outstanding", 64'(outstanding_o), 64'd1);

    // ---- wrong owner: cp1 returns id=2, which cp0 owns ----
    set_results(2'b10, 4'd2, 4'd0, 32'h2, 32'h0);
    result_ready_i = 1'b1;
    tick();
    idle_inputs();
    check("owner_err", 64'(err_o), 64'd1);
    check("owner_err_cleared", 64'(outstanding_o), 64'd0);
    tick();
    check("owner_err_pulse", 64'(err_o), 64'd0);

    // ---- unissued id=7 from cp0 ----
    set_results(2'b01, 4'd0, 4'd7, 32'h0, 32'h77);
    result_ready_i = 1'b1;
    tick();
    idle_inputs();
    check("unissued_err", 64'(err_o), 64'd1);

    // ---- kill id=4 ----
    do_issue(4'd4, 2'b10, 2'b00);
    tick();
    idle_inputs();
    check("iss4_outstanding", 64'(outstanding_o), 64'd1);
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd4;
    commit_kill_i  = 1'b1;
    settle();
    check("kill4_kill", 64'(cp_commit_kill_o), 64'b11);
    tick();
    idle_inputs();
    check("kill4_outstanding", 64'(outstanding_o), 64'd0);
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd9;
    settle();
    check("free_commit_kill", 64'(cp_commit_kill_o), 64'b11);
    tick();
    idle_inputs();

    // ---- kill and result for id=6 in the same cycle ----
    do_issue(4'd6, 2'b10, 2'b00);
    tick();
    idle_inputs();
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd6;
    commit_kill_i  = 1'b1;
    set_results(2'b10, 4'd6, 4'd0, 32'h6, 32'h0);
    result_ready_i = 1'b1;
    tick();
    idle_inputs();
    check("kill_res_err", 64'(err_o), 64'd0);
    check("kill_res_outstanding", 64'(outstanding_o), 64'd0);

    // ---- outstanding count with two IDs in flight, then reset mid-operation ----
    do_issue(4'd10, 2'b01, 2'b00);
    tick();
    do_issue(4'd11, 2'b10, 2'b00);
    tick();
    idle_inputs();
    check("two_outstanding", 64'(outstanding_o), 64'd2);
    rst_ni = 1'b0;
    settle();
    check("midrst_outstanding", 64'(outstanding_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // ---- round robin from pointer 0: cp0, cp1, cp0 ----
    set_results(2'b11, 4'd2, 4'd1, 32'hB1B1B1B1, 32'hA0A0A0A0);
    result_ready_i = 1'b1;
    settle();
    check("rr0_id", 64'(result_id_o), 64'd1);
    check("rr0_ready_o", 64'(cp_result_ready_o), 64'b01);
    tick();
    check("rr1_id", 64'(result_id_o), 64'd2);
    check("rr1_data", 64'(result_data_o), 64'hB1B1B1B1);
    check("rr1_ready_o", 64'(cp_result_ready_o), 64'b10);
    tick();
    check("rr2_id", 64'(result_id_o), 64'd1);
    tick();
    // Pointer is now at cp1; stall the core for three cycles.
    result_ready_i = 1'b0;
    settle();
    check("stall_gnt_id", 64'(result_id_o), 64'd2);
    check("stall_ready_o", 64'(cp_result_ready_o), 64'b00);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_hold_id", 64'(result_id_o), 64'd2);
      check("stall_hold_data", 64'(result_data_o), 64'hB1B1B1B1);
    end
    result_ready_i = 1'b1;
    settle();
    check("stall_release_ready", 64'(cp_result_ready_o), 64'b10);
    tick();
    check("after_stall_id", 64'(result_id_o), 64'd1);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
